// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the IF-stage branch predictor: 2-bit counter states
// and the reset/allocation values used by the BTB.
package bp_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RESET = CTR_WNT;
    localparam ctr_e CTR_ALLOC = CTR_WT;

    localparam int unsigned PC_W = 32;

    // Upper half of the counter range predicts taken.
    function automatic logic ctr_predicts_taken(input ctr_e ctr);
        return (ctr == CTR_WT) || (ctr == CTR_ST);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/resolve bundle between the pipeline and the branch predictor.
// master = pipeline side, slave = predictor side.
interface branch_predictor_if;

    logic        if_pc_valid_unused;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] correct_pc;
    logic [31:0] branch_count;
    logic [31:0] miss_count;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, mispredict, correct_pc,
               branch_count, miss_count
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, mispredict, correct_pc,
               branch_count, miss_count
    );

endinterface

// File: rtl/branch_predictor_sat_counter.sv
// 2-bit saturating counter next-state function used on the BTB update path.
module bp_sat_counter
    import bp_pkg::*;
(
    input  ctr_e ctr_i,
    input  logic taken_i,
    output ctr_e ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        unique case (ctr_i)
            CTR_SNT: ctr_o = taken_i ? CTR_WNT : CTR_SNT;
            CTR_WNT: ctr_o = taken_i ? CTR_WT  : CTR_SNT;
            CTR_WT:  ctr_o = taken_i ? CTR_ST  : CTR_WNT;
            CTR_ST:  ctr_o = taken_i ? CTR_ST  : CTR_WT;
            default: ctr_o = ctr_i;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency lookup on IF_PC,
// registered update from EX resolution, mispredict redirect and statistics.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES    = 16,
    parameter int unsigned INDEX_BITS = $clog2(ENTRIES)
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IF_PC,
    output logic        PRED_TAKEN,
    output logic [31:0] PRED_TARGET,
    input  logic        EX_VALID,
    input  logic [31:0] EX_PC,
    input  logic        EX_TAKEN,
    input  logic [31:0] EX_TARGET,
    input  logic        EX_PRED_TAKEN,
    input  logic [31:0] EX_PRED_TARGET,
    output logic        MISPREDICT,
    output logic [31:0] CORRECT_PC,
    output logic [31:0] BRANCH_COUNT,
    output logic [31:0] MISS_COUNT
);

    localparam int unsigned TAG_BITS = PC_W - INDEX_BITS - 2;

    typedef logic [INDEX_BITS-1:0] idx_t;
    typedef logic [TAG_BITS-1:0]   tag_t;

    logic        valid_q  [ENTRIES];
    tag_t        tag_q    [ENTRIES];
    logic [31:0] target_q [ENTRIES];
    ctr_e        ctr_q    [ENTRIES];

    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] miss_cnt_q,   miss_cnt_d;

    idx_t        if_idx, ex_idx;
    tag_t        if_tag, ex_tag;
    logic        if_hit, ex_hit;

    logic        upd_we;
    logic        upd_valid_d;
    tag_t        upd_tag_d;
    logic [31:0] upd_target_d;
    ctr_e        upd_ctr_d;
    ctr_e        ctr_next;

    // Lookup reads the registered table directly, so a same-cycle update
    // to the same index is not visible until the following cycle.
    always_comb begin
        if_idx      = IF_PC[INDEX_BITS+1:2];
        if_tag      = IF_PC[PC_W-1:INDEX_BITS+2];
        if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        PRED_TAKEN  = if_hit && ctr_predicts_taken(ctr_q[if_idx]);
        PRED_TARGET = PRED_TAKEN ? target_q[if_idx] : IF_PC + 32'd4;
    end

    always_comb begin
        MISPREDICT = EX_VALID && !RESET &&
                     ((EX_PRED_TAKEN != EX_TAKEN) ||
                      (EX_TAKEN && (EX_PRED_TARGET != EX_TARGET)));
        CORRECT_PC = RESET ? '0 : (EX_TAKEN ? EX_TARGET : EX_PC + 32'd4);
    end

    always_comb begin
        ex_idx = EX_PC[INDEX_BITS+1:2];
        ex_tag = EX_PC[PC_W-1:INDEX_BITS+2];
        ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    end

    bp_sat_counter u_sat_counter (
        .ctr_i   (ctr_q[ex_idx]),
        .taken_i (EX_TAKEN),
        .ctr_o   (ctr_next)
    );

    // Not-taken misses leave the entry alone so an alias never evicts it.
    always_comb begin
        upd_we       = 1'b0;
        upd_valid_d  = valid_q[ex_idx];
        upd_tag_d    = tag_q[ex_idx];
        upd_target_d = target_q[ex_idx];
        upd_ctr_d    = ctr_q[ex_idx];
        if (EX_VALID) begin
            if (ex_hit) begin
                upd_we    = 1'b1;
                upd_ctr_d = ctr_next;
                if (EX_TAKEN) begin
                    upd_target_d = EX_TARGET;
                end
            end else if (EX_TAKEN) begin
                upd_we       = 1'b1;
                upd_valid_d  = 1'b1;
                upd_tag_d    = ex_tag;
                upd_target_d = EX_TARGET;
                upd_ctr_d    = CTR_ALLOC;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
        end else if (upd_we) begin
            valid_q[ex_idx]  <= upd_valid_d;
            tag_q[ex_idx]    <= upd_tag_d;
            target_q[ex_idx] <= upd_target_d;
            ctr_q[ex_idx]    <= upd_ctr_d;
        end
    end

    always_comb begin
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (EX_VALID && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
        if (MISPREDICT && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign BRANCH_COUNT = branch_cnt_q;
    assign MISS_COUNT   = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, reset corner case, and
// randomized traffic against an array-based behavioural model.
module tb_branch_predictor;

    localparam int unsigned ENTRIES = 16;

    logic CLK;
    logic RESET;

    branch_predictor_if bus ();

    branch_predictor #(
        .ENTRIES (ENTRIES)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .IF_PC          (bus.if_pc),
        .PRED_TAKEN     (bus.pred_taken),
        .PRED_TARGET    (bus.pred_target),
        .EX_VALID       (bus.ex_valid),
        .EX_PC          (bus.ex_pc),
        .EX_TAKEN       (bus.ex_taken),
        .EX_TARGET      (bus.ex_target),
        .EX_PRED_TAKEN  (bus.ex_pred_taken),
        .EX_PRED_TARGET (bus.ex_pred_target),
        .MISPREDICT     (bus.mispredict),
        .CORRECT_PC     (bus.correct_pc),
        .BRANCH_COUNT   (bus.branch_count),
        .MISS_COUNT     (bus.miss_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural model: entries kept as plain integers, index/tag by division.
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    longint      m_bc, m_mc;

    function automatic int unsigned m_index(input logic [31:0] pc);
        return (pc / 4) % ENTRIES;
    endfunction

    function automatic logic [31:0] m_tagof(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_bc = 0; m_mc = 0;
    endfunction

    function automatic void m_lookup(input logic [31:0] pc, output logic t, output logic [31:0] tgt);
        int unsigned i;
        i   = m_index(pc);
        t   = m_valid[i] && (m_tag[i] == m_tagof(pc)) && (m_ctr[i] >= 2);
        tgt = t ? m_tgt[i] : pc + 32'd4;
    endfunction

    function automatic logic m_mis(input logic rst, v, t, pt, input logic [31:0] tgt, ptgt);
        return v && !rst && ((pt != t) || (t && ptgt != tgt));
    endfunction

    function automatic void m_update(input logic rst, v, t, pt, input logic [31:0] pc, tgt, ptgt);
        int unsigned i;
        if (rst) begin
            m_reset();
            return;
        end
        if (!v) return;
        if (m_mis(rst, v, t, pt, tgt, ptgt) && m_mc < 64'hFFFF_FFFF) m_mc++;
        if (m_bc < 64'hFFFF_FFFF) m_bc++;
        i = m_index(pc);
        if (m_valid[i] && m_tag[i] == m_tagof(pc)) begin
            m_ctr[i] = t ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                         : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
            if (t) m_tgt[i] = tgt;
        end else if (t) begin
            m_valid[i] = 1; m_tag[i] = m_tagof(pc); m_tgt[i] = tgt; m_ctr[i] = 2;
        end
    endfunction

    typedef struct {
        logic [31:0] if_pc;
        logic        ex_valid;
        logic [31:0] ex_pc;
        logic        ex_taken;
        logic [31:0] ex_target;
        logic        ex_pt;
        logic [31:0] ex_ptgt;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_mis;
        logic [31:0] e_cpc;
        logic [31:0] e_bc;
        logic [31:0] e_mc;
    } vec_t;

    vec_t vecs [18];

    task automatic drive(input logic rst, input logic [31:0] ifpc, input logic v,
                         input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                         input logic pt, input logic [31:0] ptgt);
        RESET              = rst;
        bus.if_pc          = ifpc;
        bus.ex_valid       = v;
        bus.ex_pc          = pc;
        bus.ex_taken       = t;
        bus.ex_target      = tgt;
        bus.ex_pred_taken  = pt;
        bus.ex_pred_target = ptgt;
    endtask

    initial begin
        logic        r_rst, r_v, r_t, r_pt, e_pt;
        logic [31:0] r_if, r_pc, r_tgt, r_ptgt, e_tgt, lk_tgt;
        logic        lk_t;

        //            if_pc         v  ex_pc         t  target        pt ptgt          ept eptgt        mis cpc           bc mc
        vecs[0]  = '{32'h100,      0, 32'h100,      0, 32'h0,        0, 32'h0,        0, 32'h104,      0, 32'h104,      0,  0};
        vecs[1]  = '{32'h100,      1, 32'h100,      1, 32'h80,       0, 32'h104,      0, 32'h104,      1, 32'h80,       0,  0};
        vecs[2]  = '{32'h100,      0, 32'h100,      0, 32'h0,        0, 32'h0,        1, 32'h80,       0, 32'h104,      1,  1};
        vecs[3]  = '{32'h100,      1, 32'h100,      0, 32'h0,        1, 32'h80,       1, 32'h80,       1, 32'h104,      1,  1};
        vecs[4]  = '{32'h100,      1, 32'h100,      0, 32'h0,        0, 32'h104,      0, 32'h104,      0, 32'h104,      2,  2};
        vecs[5]  = '{32'h100,      1, 32'h100,      0, 32'h0,        0, 32'h104,      0, 32'h104,      0, 32'h104,      3,  2};
        vecs[6]  = '{32'h100,      1, 32'h100,      0, 32'h0,        0, 32'h104,      0, 32'h104,      0, 32'h104,      4,  2};
        vecs[7]  = '{32'h100,      1, 32'h100,      1, 32'h80,       0, 32'h104,      0, 32'h104,      1, 32'h80,       5,  2};
        vecs[8]  = '{32'h100,      1, 32'h100,      1, 32'h80,       0, 32'h104,      0, 32'h104,      1, 32'h80,       6,  3};
        vecs[9]  = '{32'h100,      1, 32'h100,      1, 32'h90,       1, 32'h80,       1, 32'h80,       1, 32'h90,       7,  4};
        vecs[10] = '{32'h100,      1, 32'h100,      1, 32'h90,       1, 32'h90,       1, 32'h90,       0, 32'h90,       8,  5};
        vecs[11] = '{32'h100,      1, 32'h140,      0, 32'h0,        0, 32'h144,      1, 32'h90,       0, 32'h144,      9,  5};
        vecs[12] = '{32'h100,      1, 32'h140,      1, 32'h200,      0, 32'h144,      1, 32'h90,       1, 32'h200,      10, 5};
        vecs[13] = '{32'h100,      0, 32'h140,      0, 32'h0,        0, 32'h0,        0, 32'h104,      0, 32'h144,      11, 6};
        vecs[14] = '{32'h140,      0, 32'h140,      0, 32'h0,        0, 32'h0,        1, 32'h200,      0, 32'h144,      11, 6};
        vecs[15] = '{32'hFFFFFFFC, 0, 32'h140,      0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h144,      11, 6};
        vecs[16] = '{32'h304,      1, 32'h304,      1, 32'h400,      0, 32'h308,      0, 32'h308,      1, 32'h400,      11, 6};
        vecs[17] = '{32'h304,      0, 32'h304,      0, 32'h0,        0, 32'h0,        1, 32'h400,      0, 32'h308,      12, 7};

        // Reset with a resolution pending: no redirect, zero CORRECT_PC.
        drive(1, 32'h100, 1, 32'h500, 1, 32'h600, 0, 32'h504);
        @(negedge CLK); #1;
        chk("reset_mispredict", {31'd0, bus.mispredict}, 32'd0);
        chk("reset_correct_pc", bus.correct_pc, 32'd0);
        @(negedge CLK);
        drive(1, 32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0);

        for (int k = 0; k < 18; k++) begin
            @(negedge CLK);
            drive(0, vecs[k].if_pc, vecs[k].ex_valid, vecs[k].ex_pc, vecs[k].ex_taken,
                  vecs[k].ex_target, vecs[k].ex_pt, vecs[k].ex_ptgt);
            #1;
            chk($sformatf("vec%0d_pred_taken", k), {31'd0, bus.pred_taken}, {31'd0, vecs[k].e_pt});
            chk($sformatf("vec%0d_pred_target", k), bus.pred_target, vecs[k].e_ptgt);
            chk($sformatf("vec%0d_mispredict", k), {31'd0, bus.mispredict}, {31'd0, vecs[k].e_mis});
            chk($sformatf("vec%0d_correct_pc", k), bus.correct_pc, vecs[k].e_cpc);
            chk($sformatf("vec%0d_branch_count", k), bus.branch_count, vecs[k].e_bc);
            chk($sformatf("vec%0d_miss_count", k), bus.miss_count, vecs[k].e_mc);
        end

        // Reset coinciding with a taken resolution: nothing allocated, counts cleared.
        @(negedge CLK);
        drive(1, 32'h500, 1, 32'h500, 1, 32'h600, 0, 32'h504);
        #1;
        chk("rst_ex_mispredict", {31'd0, bus.mispredict}, 32'd0);
        chk("rst_ex_correct_pc", bus.correct_pc, 32'd0);
        @(negedge CLK);
        drive(0, 32'h500, 0, 32'h500, 0, 32'h0, 0, 32'h0);
        #1;
        chk("rst_ex_no_alloc_taken", {31'd0, bus.pred_taken}, 32'd0);
        chk("rst_ex_no_alloc_target", bus.pred_target, 32'h504);
        chk("rst_ex_branch_count", bus.branch_count, 32'd0);
        chk("rst_ex_miss_count", bus.miss_count, 32'd0);
        bus.if_pc = 32'h140;
        #1;
        chk("rst_table_cleared", bus.pred_target, 32'h144);
        m_reset();

        for (int c = 0; c < 600; c++) begin
            @(negedge CLK);
            r_rst = ($urandom_range(0, 59) == 0);
            r_if  = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC
                  : (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 15)) << 2);
            r_pc  = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 15)) << 2);
            r_v   = ($urandom_range(0, 3) != 0);
            r_t   = $urandom_range(0, 1) == 1;
            r_tgt = {22'd0, 8'($urandom_range(0, 3) * 16), 2'b00} + 32'h1000;
            if ($urandom_range(0, 3) != 0) begin
                m_lookup(r_pc, r_pt, r_ptgt);
            end else begin
                r_pt   = $urandom_range(0, 1) == 1;
                r_ptgt = {$urandom()} & 32'hFFFF_FFFC;
            end
            drive(r_rst, r_if, r_v, r_pc, r_t, r_tgt, r_pt, r_ptgt);
            #1;
            m_lookup(r_if, lk_t, lk_tgt);
            e_pt  = lk_t;
            e_tgt = lk_tgt;
            chk($sformatf("rnd%0d_pred_taken", c), {31'd0, bus.pred_taken}, {31'd0, e_pt});
            chk($sformatf("rnd%0d_pred_target", c), bus.pred_target, e_tgt);
            chk($sformatf("rnd%0d_mispredict", c), {31'd0, bus.mispredict},
                {31'd0, m_mis(r_rst, r_v, r_t, r_pt, r_tgt, r_ptgt)});
            chk($sformatf("rnd%0d_correct_pc", c), bus.correct_pc,
                r_rst ? 32'd0 : (r_t ? r_tgt : r_pc + 32'd4));
            chk($sformatf("rnd%0d_branch_count", c), bus.branch_count, 32'(m_bc));
            chk($sformatf("rnd%0d_miss_count", c), bus.miss_count, 32'(m_mc));
            @(posedge CLK);
            m_update(r_rst, r_v, r_t, r_pt, r_pc, r_tgt, r_ptgt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
